// File: rtl/u109_pkg.sv
// Shared definitions for the U109 burst buffer: state encoding and line geometry.
package u109_pkg;

  localparam int unsigned LINE_BEATS = 4;
  localparam int unsigned DW         = 32;

  typedef enum logic [1:0] {
    BB_IDLE  = 2'd0,
    BB_RD    = 2'd1,
    BB_WR    = 2'd2,
    BB_ABORT = 2'd3
  } bb_state_e;

endpackage

// File: rtl/u109_line_ram.sv
// One-line register file: single write port, combinational CPU-side and PCI-side read ports.
module u109_line_ram #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] craddr_i,
  output logic [Width-1:0]         crdata_o,
  input  logic [$clog2(Depth)-1:0] praddr_i,
  output logic [Width-1:0]         prdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Synchronous clear so cpu_rdata/pci_wdata read back zero out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign crdata_o = mem_q[craddr_i];
  assign prdata_o = mem_q[praddr_i];

endmodule

// File: rtl/u109_burst_buffer.sv
// Four-longword line buffer between the 68040 front end and the U109 PCI initiator.
module u109_burst_buffer #(
  parameter int unsigned DEPTH = u109_pkg::LINE_BEATS,
  parameter int unsigned DW    = u109_pkg::DW
) (
  input  logic          CLK40,
  input  logic          RESETn,
  input  logic          cyc_start,
  input  logic          cyc_rnw,
  input  logic          cyc_line,
  input  logic          tack_beat,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          PCI_TACK,
  output logic          rd_ready,
  output logic          wr_ready,
  output logic          BURST,
  output logic          busy,
  output logic          tea_req,
  output logic          pci_start,
  output logic          pci_rnw,
  output logic [2:0]    pci_nbeats,
  input  logic          pci_rvalid,
  input  logic [DW-1:0] pci_rdata,
  output logic          pci_wvalid,
  output logic [DW-1:0] pci_wdata,
  input  logic          pci_wtake,
  input  logic          pci_done,
  input  logic          pci_abort
);
  import u109_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  bb_state_e  state_q;
  logic [2:0] nbeats_q, rx_cnt_q, beat_cnt_q, pci_cnt_q;
  logic       done_seen_q, tack_sent_q;
  logic       pci_tack_q, burst_q, tea_q, pci_start_q, pci_rnw_q;

  logic          in_rd, in_wr, exit_now, rx_push, beat_adv, wr_take;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;

  always_comb begin
    in_rd    = (state_q == BB_RD);
    in_wr    = (state_q == BB_WR);
    // Abort outranks every other event, including completion.
    exit_now = ((in_rd && (beat_cnt_q == nbeats_q)) || (in_wr && (pci_cnt_q == nbeats_q))) &&
               (done_seen_q || pci_done) && !pci_abort;
    rx_push  = in_rd && pci_rvalid && (rx_cnt_q < nbeats_q) && !pci_abort && !exit_now;
    beat_adv = (in_rd || in_wr) && tack_beat && (beat_cnt_q < nbeats_q) && !pci_abort &&
               !exit_now;
    wr_take  = in_wr && pci_wtake && (pci_cnt_q < beat_cnt_q);
    ram_we    = rx_push || (in_wr && beat_adv);
    ram_waddr = rx_push ? rx_cnt_q[AW-1:0] : beat_cnt_q[AW-1:0];
    ram_wdata = rx_push ? pci_rdata : cpu_wdata;
  end

  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      state_q     <= BB_IDLE;
      nbeats_q    <= 3'd0;
      rx_cnt_q    <= 3'd0;
      beat_cnt_q  <= 3'd0;
      pci_cnt_q   <= 3'd0;
      done_seen_q <= 1'b0;
      tack_sent_q <= 1'b0;
      pci_tack_q  <= 1'b0;
      burst_q     <= 1'b0;
      tea_q       <= 1'b0;
      pci_start_q <= 1'b0;
      pci_rnw_q   <= 1'b0;
    end else begin
      pci_tack_q  <= 1'b0;
      tea_q       <= 1'b0;
      pci_start_q <= 1'b0;
      unique case (state_q)
        BB_IDLE: begin
          if (cyc_start) begin
            pci_rnw_q   <= cyc_rnw;
            burst_q     <= cyc_line;
            nbeats_q    <= cyc_line ? 3'd4 : 3'd1;
            rx_cnt_q    <= 3'd0;
            beat_cnt_q  <= 3'd0;
            pci_cnt_q   <= 3'd0;
            done_seen_q <= 1'b0;
            tack_sent_q <= 1'b0;
            pci_start_q <= 1'b1;
            state_q     <= cyc_rnw ? BB_RD : BB_WR;
          end
        end
        BB_RD, BB_WR: begin
          if (pci_abort || exit_now) begin
            state_q     <= pci_abort ? BB_ABORT : BB_IDLE;
            tea_q       <= pci_abort;
            nbeats_q    <= 3'd0;
            rx_cnt_q    <= 3'd0;
            beat_cnt_q  <= 3'd0;
            pci_cnt_q   <= 3'd0;
            done_seen_q <= 1'b0;
            tack_sent_q <= 1'b0;
            burst_q     <= 1'b0;
          end else begin
            if (rx_push)  rx_cnt_q   <= rx_cnt_q + 3'd1;
            if (beat_adv) beat_cnt_q <= beat_cnt_q + 3'd1;
            if (wr_take)  pci_cnt_q  <= pci_cnt_q + 3'd1;
            if (pci_done) done_seen_q <= 1'b1;
            // Reads release the first beat once data lands; writes release it immediately.
            if (in_rd) begin
              pci_tack_q <= rx_push && (rx_cnt_q == 3'd0);
            end else begin
              pci_tack_q  <= !tack_sent_q;
              tack_sent_q <= 1'b1;
            end
          end
        end
        BB_ABORT: state_q <= BB_IDLE;
        default:  state_q <= BB_IDLE;
      endcase
    end
  end

  assign PCI_TACK   = pci_tack_q;
  assign BURST      = burst_q;
  assign tea_req    = tea_q;
  assign pci_start  = pci_start_q;
  assign pci_rnw    = pci_rnw_q;
  assign pci_nbeats = nbeats_q;
  assign busy       = (state_q != BB_IDLE);
  assign rd_ready   = in_rd && (beat_cnt_q >= 3'd1) && (rx_cnt_q > beat_cnt_q) &&
                      (beat_cnt_q < nbeats_q);
  assign wr_ready   = in_wr && (beat_cnt_q >= 3'd1) && (beat_cnt_q < nbeats_q);
  assign pci_wvalid = in_wr && (pci_cnt_q < beat_cnt_q);

  u109_line_ram #(
    .Depth (DEPTH),
    .Width (DW)
  ) u_line_ram (
    .clk_i    (CLK40),
    .rst_ni   (RESETn),
    .we_i     (ram_we),
    .waddr_i  (ram_waddr),
    .wdata_i  (ram_wdata),
    .craddr_i (beat_cnt_q[AW-1:0]),
    .crdata_o (cpu_rdata),
    .praddr_i (pci_cnt_q[AW-1:0]),
    .prdata_o (pci_wdata)
  );

endmodule

// File: tb/tb_u109_burst_buffer.sv
// Bench for u109_burst_buffer: randomized transactions checked every cycle against a reference model.
module tb_u109_burst_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc_start, cyc_rnw, cyc_line, tack_beat;
  logic [31:0] cpu_wdata, cpu_rdata, pci_rdata, pci_wdata;
  logic        PCI_TACK, rd_ready, wr_ready, BURST, busy, tea_req;
  logic        pci_start, pci_rnw, pci_rvalid, pci_wvalid, pci_wtake, pci_done, pci_abort;
  logic [2:0]  pci_nbeats;

  always #12.5 clk = ~clk;

  u109_burst_buffer dut (
    .CLK40      (clk),
    .RESETn     (rst_n),
    .cyc_start  (cyc_start),
    .cyc_rnw    (cyc_rnw),
    .cyc_line   (cyc_line),
    .tack_beat  (tack_beat),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .PCI_TACK   (PCI_TACK),
    .rd_ready   (rd_ready),
    .wr_ready   (wr_ready),
    .BURST      (BURST),
    .busy       (busy),
    .tea_req    (tea_req),
    .pci_start  (pci_start),
    .pci_rnw    (pci_rnw),
    .pci_nbeats (pci_nbeats),
    .pci_rvalid (pci_rvalid),
    .pci_rdata  (pci_rdata),
    .pci_wvalid (pci_wvalid),
    .pci_wdata  (pci_wdata),
    .pci_wtake  (pci_wtake),
    .pci_done   (pci_done),
    .pci_abort  (pci_abort)
  );

  int n_pass = 0, n_fail = 0, n_total = 0;

  // Reference model: phase 0 idle, 1 read, 2 write, 3 abort.
  int          m_ph, m_nb, m_rx, m_beat, m_pc, m_age;
  bit          m_done, m_rnw, m_burst, m_tack, m_tea, m_start;
  logic [31:0] m_buf [4];
  logic [31:0] rd_pat [4];

  function automatic bit rd_ready_e();
    return (m_ph == 1) && (m_beat >= 1) && (m_rx > m_beat) && (m_beat < m_nb);
  endfunction

  function automatic bit wr_ready_e();
    return (m_ph == 2) && (m_beat >= 1) && (m_beat < m_nb);
  endfunction

  function automatic bit wvalid_e();
    return (m_ph == 2) && (m_pc < m_beat);
  endfunction

  task automatic model_clear();
    m_nb = 0; m_rx = 0; m_beat = 0; m_pc = 0; m_age = 0; m_done = 0; m_burst = 0;
  endtask

  task automatic model_edge();
    m_tack = 0; m_tea = 0; m_start = 0;
    if (!rst_n) begin
      m_ph = 0; m_rnw = 0; model_clear();
      for (int i = 0; i < 4; i++) m_buf[i] = '0;
    end else if (m_ph == 3) begin
      m_ph = 0;
    end else if (m_ph == 0) begin
      if (cyc_start) begin
        model_clear();
        m_rnw = cyc_rnw; m_burst = cyc_line; m_nb = cyc_line ? 4 : 1;
        m_start = 1; m_ph = cyc_rnw ? 1 : 2;
      end
    end else if (pci_abort) begin
      m_ph = 3; m_tea = 1; model_clear();
    end else if (((m_ph == 1) ? m_beat : m_pc) == m_nb && (m_done || pci_done)) begin
      m_ph = 0; model_clear();
    end else begin
      if (m_ph == 1) begin
        if (pci_rvalid && m_rx < m_nb) begin
          m_buf[m_rx] = pci_rdata; m_rx++; m_tack = (m_rx == 1);
        end
        if (tack_beat && m_beat < m_nb) m_beat++;
      end else begin
        m_age++; m_tack = (m_age == 1);
        if (pci_wtake && m_pc < m_beat) m_pc++;
        if (tack_beat && m_beat < m_nb) begin m_buf[m_beat] = cpu_wdata; m_beat++; end
      end
      if (pci_done) m_done = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("PCI_TACK",   PCI_TACK,   m_tack);
    chk("rd_ready",   rd_ready,   rd_ready_e());
    chk("wr_ready",   wr_ready,   wr_ready_e());
    chk("BURST",      BURST,      m_burst);
    chk("busy",       busy,       m_ph != 0);
    chk("tea_req",    tea_req,    m_tea);
    chk("pci_start",  pci_start,  m_start);
    chk("pci_rnw",    pci_rnw,    m_rnw);
    chk("pci_nbeats", pci_nbeats, m_nb);
    chk("pci_wvalid", pci_wvalid, wvalid_e());
    chk("cpu_rdata",  cpu_rdata,  m_buf[m_beat % 4]);
    chk("pci_wdata",  pci_wdata,  m_buf[m_pc % 4]);
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
    cyc_start = 0; tack_beat = 0; pci_rvalid = 0; pci_wtake = 0; pci_done = 0; pci_abort = 0;
  endtask

  // gap < 0 means random PCI pacing; late_cpu holds later CPU beats until pci_done is seen.
  task automatic run_txn(input bit rnw, input bit line, input int gap, input bit use_pat,
                         input int abort_beat, input bit late_cpu, input bit stall_wr);
    int wait_cnt = 0;
    int guard = 0;
    cyc_start = 1; cyc_rnw = rnw; cyc_line = line;
    step();
    while (m_ph != 0 && guard < 80) begin
      guard++;
      if (guard == 2) begin
        cyc_start = 1; cyc_rnw = $urandom_range(0, 1) == 1; cyc_line = 1;
      end
      if (m_ph == 1) begin
        if (m_rx < m_nb) begin
          if (gap >= 0 ? (wait_cnt >= gap) : ($urandom_range(0, 2) == 0)) begin
            pci_rvalid = 1; pci_rdata = use_pat ? rd_pat[m_rx] : $urandom(); wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end else if (!m_done) begin
          pci_done = 1; pci_rvalid = 1; pci_rdata = $urandom();
        end
        tack_beat = m_tack || (rd_ready_e() && !(late_cpu && !m_done));
      end else if (m_ph == 2) begin
        tack_beat = m_tack || (wr_ready_e() && (gap >= 0 || $urandom_range(0, 1) == 1));
        cpu_wdata = use_pat ? 32'h0000_00A0 + m_beat : $urandom();
        pci_wtake = wvalid_e() && (stall_wr ? (m_beat == m_nb) : ($urandom_range(0, 1) == 1));
        if (m_pc == m_nb && !m_done) pci_done = 1;
      end
      if (abort_beat >= 0 && tack_beat && m_beat == abort_beat) pci_abort = 1;
      step();
    end
    chk("txn_ends_idle", busy, 1'b0);
    step();
  endtask

  initial begin
    rst_n = 0; cyc_start = 0; cyc_rnw = 0; cyc_line = 0; tack_beat = 0;
    cpu_wdata = '0; pci_rdata = '0; pci_rvalid = 0; pci_wtake = 0; pci_done = 0; pci_abort = 0;
    @(posedge clk);
    model_edge();
    #1;
    step();
    rst_n = 1;
    step();

    rd_pat[0] = 32'hDEAD_BEEF;
    run_txn(1, 0, 2, 1, -1, 0, 0);
    chk("single_rd_data", dut.u_line_ram.mem_q[0], 32'hDEAD_BEEF);

    rd_pat[0] = 32'h1111_1111; rd_pat[1] = 32'h2222_2222;
    rd_pat[2] = 32'h3333_3333; rd_pat[3] = 32'h4444_4444;
    run_txn(1, 1, 2, 1, -1, 0, 0);
    run_txn(0, 1, 0, 1, -1, 0, 1);
    run_txn(1, 1, 1, 0,  1, 0, 0);
    run_txn(1, 1, 0, 0, -1, 1, 0);
    run_txn(0, 0, 0, 0, -1, 0, 0);

    // Reset in the middle of a burst read.
    cyc_start = 1; cyc_rnw = 1; cyc_line = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      pci_rvalid = (i % 2 == 0); pci_rdata = $urandom(); tack_beat = m_tack;
      step();
    end
    rst_n = 0;
    step();
    rst_n = 1;
    step();
    chk("rst_no_tea", tea_req, 1'b0);

    for (int t = 0; t < 14; t++) begin
      run_txn($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, -1, 0,
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/u109_burst_buffer.md
# u109_burst_buffer

Four-longword line buffer between the 68040 bus front end and the U109 PCI initiator core. It accepts a CPU cycle start, launches the PCI transaction, and buffers single or 4-beat burst data in either direction. It generates the `PCI_TACK`, `rd_ready`, `wr_ready` and `BURST` qualifiers that the downstream cycle-termination stage turns into `TACKn` beats. It also consumes that stage's per-beat strobe to advance the buffer.

## Interface
Parameters:
- `DEPTH`, 4: buffer entries; fixed at one 68040 line.
- `DW`, 32: data width.

Ports:
- `CLK40  in  1`: 40 MHz bus clock; all logic on the rising edge.
- `RESETn  in  1`: reset, synchronous, active-low.
- `cyc_start  in  1`: one-cycle pulse; a decoded PCI-space CPU cycle is starting.
- `cyc_rnw  in  1`: direction, sampled at `cyc_start`; 1 = read.
- `cyc_line  in  1`: sampled at `cyc_start`; 1 = 4-beat burst (SIZ = line).
- `tack_beat  in  1`: one-cycle pulse per `TACKn` beat issued by the termination stage.
- `cpu_wdata  in  DW`: 68040 write data.
- `cpu_rdata  out  DW`: read data for the current beat, `buf[beat_cnt]`.
- `PCI_TACK  out  1`: one-cycle pulse; first beat may terminate.
- `rd_ready  out  1`: next read beat (beats 1–3) is buffered.
- `wr_ready  out  1`: buffer can accept the next write beat (beats 1–3).
- `BURST  out  1`: registered `cyc_line`; held for the whole cycle.
- `busy  out  1`: any state other than IDLE.
- `tea_req  out  1`: one-cycle pulse; the cycle aborted and a bus error is requested.
- `pci_start  out  1`: one-cycle pulse to the PCI core.
- `pci_rnw  out  1`: registered direction to the PCI core.
- `pci_nbeats  out  3`: beat count to the PCI core, 1 or 4.
- `pci_rvalid  in  1`: the PCI core delivers read data this cycle.
- `pci_rdata  in  DW`: PCI read data.
- `pci_wvalid  out  1`: buffered write data is available to the PCI core.
- `pci_wdata  out  DW`: write data, `buf[pci_cnt]`.
- `pci_wtake  in  1`: the PCI core consumed `pci_wdata` this cycle.
- `pci_done  in  1`: one-cycle pulse; the PCI transaction completed.
- `pci_abort  in  1`: master/target abort.

## Operation
- States: IDLE, RD, WR, ABORT.
- Counters are 3-bit, range 0..4: `nbeats` (1 or 4), `rx_cnt` (PCI side), `beat_cnt` (CPU side), `pci_cnt` (write drain). Buffer index is the low 2 bits of the relevant counter.
- IDLE:
  - On `cyc_start`: latch `cyc_rnw` into `pci_rnw` and `cyc_line` into `BURST`.
  - Set `nbeats` to 4 if line, else 1; clear all counters.
  - Pulse `pci_start`; go to RD if read, WR if write.
  - `cyc_start` while busy is ignored.
- RD:
  - Each `pci_rvalid` writes `buf[rx_cnt]` and increments `rx_cnt`. `pci_rvalid` with `rx_cnt == nbeats` is dropped.
  - `PCI_TACK` pulses once, the cycle after the first push (`rx_cnt` 0→1).
  - `rd_ready = (beat_cnt >= 1) && (rx_cnt > beat_cnt) && (beat_cnt < nbeats)`.
  - `tack_beat` increments `beat_cnt`.
  - Exit to IDLE when `beat_cnt == nbeats` and `pci_done` has been seen (sticky flag).
- WR:
  - `PCI_TACK` pulses the cycle after entry.
  - Each `tack_beat` writes `cpu_wdata` into `buf[beat_cnt]` and increments `beat_cnt`.
  - `wr_ready = (beat_cnt >= 1) && (beat_cnt < nbeats)`.
  - `pci_wvalid = pci_cnt < beat_cnt`; `pci_wtake` increments `pci_cnt`.
  - Exit to IDLE when `pci_cnt == nbeats` and `pci_done` has been seen.
- ABORT:
  - `pci_abort` in RD or WR enters ABORT: pulse `tea_req`, clear counters and flags, drop all ready outputs.
  - Next cycle: IDLE.
- Simultaneous events:
  - `pci_abort` wins over `tack_beat` and `pci_rvalid`.
  - `pci_rvalid` and `tack_beat` in the same cycle both take effect.
  - `pci_done` arriving before the final CPU beat is latched and honoured later.

## Timing
- Reset values: all outputs 0, `cpu_rdata` = 0, state IDLE.
- Synchronous reset mid-cycle clears everything on the next edge; no `tea_req` is issued.
- Outputs are registered, except `rd_ready`, `wr_ready`, `pci_wvalid`, `cpu_rdata` and `pci_wdata`, which are decoded from registered counters.
- The termination stage samples these outputs on the following falling edge (half-cycle setup).
- Read latency: first `pci_rvalid` → `PCI_TACK` high 1 cycle later.
- Write latency: `cyc_start` → `PCI_TACK` 2 cycles later.
- `pci_start` → 1 cycle after `cyc_start`.
- `busy` rises 1 cycle after `cyc_start` and falls on the IDLE re-entry edge.

## Structure
- Shared package `u109_pkg`: state encodings (`BB_IDLE`, `BB_RD`, `BB_WR`, `BB_ABORT`), `LINE_BEATS = 4`, `DW`.
- One natural sub-module: `u109_line_ram`, a 4×32 register file with one write port and two combinational read ports (CPU and PCI).

## Test plan
- Single read: `cyc_start`, `rnw = 1`, `line = 0`; `pci_rvalid` with `0xDEADBEEF` at cycle 3 → `PCI_TACK` at cycle 4, `cpu_rdata = 0xDEADBEEF`, `rd_ready` never high. `pci_done` at 5 → IDLE at 6.
- Burst read: 4 `pci_rvalid` beats (`0x11111111`..`0x44444444`) with 2-cycle gaps; `tack_beat` each cycle `rd_ready` is high → `rd_ready` only while `rx_cnt > beat_cnt`, data returned in order, exactly 1 `PCI_TACK`.
- Burst write: `tack_beat` ×4 with `0xA0`..`0xA3`, `pci_wtake` stalled until beat 4 → `wr_ready` high after beat 1 until beat 4; `pci_wdata` then sequences `0xA0`..`0xA3`; exit after `pci_done`.
- Abort: `pci_abort` coincident with the 2nd `tack_beat` of a burst read → `tea_req` 1-cycle pulse, `beat_cnt` not incremented, IDLE 2 cycles later.
- Early done and reset: `pci_done` before the last CPU beat → no exit until `beat_cnt = 4`. Separately, `RESETn = 0` mid-burst → all outputs 0 next edge, no `tea_req`.
